// File: rtl/gemm_pkg.sv
// Shared defaults and helpers for the GEMM stream bridge and its controller.
package gemm_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_SRC_LEN = 32;
    localparam int DEF_PRM_LEN = 32;
    localparam int DEF_DST_LEN = 16;
    localparam int DEF_DST_PKT = 4;

    typedef logic [DEF_DW-1:0] word_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry valid/ready buffer; ready is either registered (from next occupancy)
// or taken directly from the current occupancy.
module axis_skid2 #(
    parameter int W         = 33,
    parameter bit REG_READY = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready_en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] e0, e1;
    logic [1:0]   count, count_nx;
    logic         do_push, do_pop;

    assign do_push   = in_valid & in_ready;
    assign do_pop    = out_ready & (count != 2'd0);
    assign out_valid = (count != 2'd0);
    assign out_data  = e0;

    always_comb begin
        count_nx = count;
        if (do_push && !do_pop)
            count_nx = count + 2'd1;
        else if (do_pop && !do_push)
            count_nx = count - 2'd1;
    end

    // e0 is always the head; a pop shifts e1 forward or refills from the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0    <= '0;
            e1    <= '0;
            count <= '0;
        end else begin
            count <= count_nx;
            if (do_pop) begin
                e0 <= (count == 2'd2) ? e1 : in_data;
                if (do_push && count == 2'd2)
                    e1 <= in_data;
            end else if (do_push) begin
                if (count == 2'd0)
                    e0 <= in_data;
                else
                    e1 <= in_data;
            end
        end
    end

    generate
        if (REG_READY) begin : g_reg_ready
            logic ready_q;
            always_ff @(posedge clk) begin
                if (reset)
                    ready_q <= 1'b0;
                else
                    ready_q <= ready_en & (count_nx != 2'd2);
            end
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = ready_en & (count != 2'd2);
        end
    endgenerate

endmodule

// File: rtl/gemm_axis_bridge.sv
// AXI-Stream bridge between the DMA and the GEMM batch controller: length-checked
// input path and tlast-generating output packer, each behind a 2-entry buffer.
module gemm_axis_bridge
    import gemm_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int SRC_LEN = DEF_SRC_LEN,
    parameter int PRM_LEN = DEF_PRM_LEN,
    parameter int DST_LEN = DEF_DST_LEN,
    parameter int DST_PKT = DEF_DST_PKT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          matw,
    input  logic          run,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic          src_valid,
    input  logic          src_ready,
    output logic [DW-1:0] src_data,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    output logic          dst_ready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    output logic          err_len,
    output logic          err_trunc,
    output logic          busy
);

    localparam int ICW  = $clog2(max2(SRC_LEN, PRM_LEN));
    localparam int OTOT = DST_LEN * DST_PKT;
    localparam int OCW  = $clog2(OTOT);
    localparam logic [ICW-1:0] SRC_LAST = ICW'(SRC_LEN - 1);
    localparam logic [ICW-1:0] PRM_LAST = ICW'(PRM_LEN - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OTOT - 1);

    logic           active, prm, prm_q, run_q;
    logic           in_avail, in_pop, in_at_last;
    logic [DW:0]    in_head, out_head;
    logic [ICW-1:0] icnt, in_last_pos;
    logic [OCW-1:0] ocnt;
    logic           out_push, out_at_last;
    logic           err_len_q, err_trunc_q;

    assign active = matw | run;
    assign prm    = matw & ~run;

    axis_skid2 #(.W(DW + 1), .REG_READY(1'b1)) u_in (
        .clk       (clk),
        .reset     (reset),
        .ready_en  (active),
        .in_valid  (s_axis_tvalid),
        .in_data   ({s_axis_tlast, s_axis_tdata}),
        .in_ready  (s_axis_tready),
        .out_valid (in_avail),
        .out_ready (src_ready & active),
        .out_data  (in_head)
    );

    assign src_valid   = in_avail & active;
    assign src_data    = in_head[DW-1:0];
    assign in_pop      = src_valid & src_ready;
    assign in_last_pos = matw ? PRM_LAST : SRC_LAST;
    assign in_at_last  = (icnt == in_last_pos);

    assign out_at_last = (ocnt == OUT_LAST);
    assign out_push    = dst_valid & dst_ready;

    axis_skid2 #(.W(DW + 1), .REG_READY(1'b0)) u_out (
        .clk       (clk),
        .reset     (reset),
        .ready_en  (1'b1),
        .in_valid  (dst_valid),
        .in_data   ({out_at_last, dst_data}),
        .in_ready  (dst_ready),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (out_head)
    );

    assign m_axis_tdata = out_head[DW-1:0];
    assign m_axis_tlast = out_head[DW] & m_axis_tvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            icnt        <= '0;
            ocnt        <= '0;
            prm_q       <= 1'b0;
            run_q       <= 1'b0;
            err_len_q   <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            prm_q <= prm;
            run_q <= run;
            if (in_pop && (in_head[DW] != in_at_last))
                err_len_q <= 1'b1;
            if ((prm != prm_q) || !active)
                icnt <= '0;
            else if (in_pop)
                icnt <= in_at_last ? '0 : icnt + 1'b1;
            // A run drop abandons the partial output packet; buffered words keep their tlast.
            if (run_q && !run && (ocnt != '0)) begin
                err_trunc_q <= 1'b1;
                ocnt        <= '0;
            end else if (out_push) begin
                ocnt <= out_at_last ? '0 : ocnt + 1'b1;
            end
        end
    end

    assign err_len   = err_len_q;
    assign err_trunc = err_trunc_q;
    assign busy      = in_avail | m_axis_tvalid | (icnt != '0) | (ocnt != '0);

endmodule

// File: tb/tb_gemm_axis_bridge.sv
// Randomized bench for gemm_axis_bridge with a queue-based stream model.
module tb_gemm_axis_bridge;
    import gemm_pkg::*;

    localparam int DW      = DEF_DW;
    localparam int SRC_LEN = 32;
    localparam int PRM_LEN = 32;
    localparam int DST_LEN = 16;
    localparam int DST_PKT = 4;
    localparam int OTOT    = DST_LEN * DST_PKT;

    typedef logic [DW:0] beat_t;

    logic          clk = 1'b0;
    logic          reset, matw, run;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          src_valid, src_ready;
    logic [DW-1:0] src_data;
    logic          dst_valid, dst_ready;
    logic [DW-1:0] dst_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          err_len, err_trunc, busy;

    always #5 clk = ~clk;

    gemm_axis_bridge #(
        .DW(DW), .SRC_LEN(SRC_LEN), .PRM_LEN(PRM_LEN), .DST_LEN(DST_LEN), .DST_PKT(DST_PKT)
    ) dut (
        .clk(clk), .reset(reset), .matw(matw), .run(run),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .err_len(err_len), .err_trunc(err_trunc), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // input-path observations
    beat_t sent_beats[$];
    beat_t send_q[$];
    word_t got_src_q[$];
    int    src_cyc_q[$];
    int    first_push_cyc, err_rise_at, flow_bad;
    bit    in_timeout;

    // output-path model and observations
    int    ocount;
    beat_t exp_m_q[$];
    beat_t got_m_q[$];
    int    out_bad, stall_seen;
    bit    out_timeout;

    task automatic apply_reset();
        reset = 1'b1; matw = 1'b0; run = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        src_ready = 1'b0; dst_valid = 1'b0; dst_data = '0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ocount = 0;
    endtask

    // rdy_mode: 0 = src_ready held 1, 1 = toggles every cycle, 2 = random
    task automatic drive_in(input int n, input int last_idx, input int rdy_mode);
        int pushed = 0, popped = 0, cyc = 0;
        send_q.delete(); sent_beats.delete(); got_src_q.delete(); src_cyc_q.delete();
        first_push_cyc = -1; err_rise_at = -1; flow_bad = 0; in_timeout = 1'b0;
        for (int i = 0; i < n; i++) begin
            word_t w = $urandom;
            send_q.push_back({(i == last_idx), w});
        end
        sent_beats = send_q;
        src_ready = 1'b1;
        s_axis_tvalid = (send_q.size() != 0);
        {s_axis_tlast, s_axis_tdata} = send_q[0];
        while (popped < n) begin
            if (cyc >= 400) begin
                in_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            if (err_len === 1'b1 && err_rise_at < 0) err_rise_at = popped;
            if (s_axis_tready !== ((pushed - popped) < 2)) flow_bad++;
            if (src_valid !== ((pushed - popped) > 0)) flow_bad++;
            if (s_axis_tvalid && s_axis_tready === 1'b1) begin
                void'(send_q.pop_front());
                if (first_push_cyc < 0) first_push_cyc = cyc;
                pushed++;
            end
            if (src_valid === 1'b1 && src_ready) begin
                got_src_q.push_back(src_data);
                src_cyc_q.push_back(cyc);
                popped++;
            end
            @(posedge clk);
            #1 cyc++;
            s_axis_tvalid = (send_q.size() != 0);
            if (send_q.size() != 0) {s_axis_tlast, s_axis_tdata} = send_q[0];
            else {s_axis_tlast, s_axis_tdata} = '0;
            case (rdy_mode)
                1:       src_ready = ~src_ready;
                2:       src_ready = 1'($urandom_range(0, 1));
                default: src_ready = 1'b1;
            endcase
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drive_out(input int n, input int stall_at, input int stall_len);
        int pushed = 0, mpend = 0, cyc = 0;
        exp_m_q.delete(); got_m_q.delete();
        out_bad = 0; stall_seen = 0; out_timeout = 1'b0;
        dst_valid = (n > 0);
        dst_data = $urandom;
        m_axis_tready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        while (pushed < n || mpend > 0) begin
            bit took = 1'b0;
            if (cyc >= 600) begin
                out_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            if (dst_ready !== (mpend < 2) || m_axis_tvalid !== (mpend > 0)) out_bad++;
            if (dst_ready === 1'b0) stall_seen++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                got_m_q.push_back({m_axis_tlast, m_axis_tdata});
                mpend--;
            end
            if (dst_valid && dst_ready === 1'b1) begin
                exp_m_q.push_back({(ocount == OTOT - 1), dst_data});
                ocount = (ocount + 1) % OTOT;
                pushed++;
                mpend++;
                took = 1'b1;
            end
            @(posedge clk);
            #1 cyc++;
            dst_valid = (pushed < n);
            if (took) dst_data = $urandom;
            m_axis_tready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        end
        dst_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        apply_reset();
        obs = {s_axis_tready, src_valid, m_axis_tvalid, m_axis_tlast,
               dst_ready, err_len, err_trunc, busy};
        total++;
        if (obs !== 8'b0000_1000) begin
            bad++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b0000_1000);
        end
    endtask

    task automatic test_param_load();
        matw = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        drive_in(32, 31, 0);
        total++;
        if (in_timeout !== 1'b0) begin bad++; $display("FAIL prm_timeout: got %0d expected 0", in_timeout); end
        total++;
        if (got_src_q.size() != 32) begin bad++; $display("FAIL prm_count: got %0d expected 32", got_src_q.size()); end
        for (int i = 0; i < 32; i++) begin
            word_t g = (i < got_src_q.size()) ? got_src_q[i] : 'x;
            total++;
            if (g !== sent_beats[i][DW-1:0]) begin
                bad++; $display("FAIL prm_data[%0d]: got %h expected %h", i, g, sent_beats[i][DW-1:0]);
            end
        end
        if (src_cyc_q.size() == 32) begin
            total++;
            if (src_cyc_q[0] != first_push_cyc + 1) begin
                bad++; $display("FAIL prm_latency: got %0d expected %0d", src_cyc_q[0], first_push_cyc + 1);
            end
            total++;
            if (src_cyc_q[31] - src_cyc_q[0] != 31) begin
                bad++; $display("FAIL prm_throughput: got %0d expected 31", src_cyc_q[31] - src_cyc_q[0]);
            end
        end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL prm_err_len: got %b expected 0", err_len); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL prm_busy_idle: got %b expected 0", busy); end
        total++;
        if (flow_bad != 0) begin bad++; $display("FAIL prm_flow: got %0d expected 0", flow_bad); end
    endtask

    task automatic test_len_error();
        matw = 1'b0; run = 1'b1;
        @(posedge clk); #1;
        drive_in(32, 30, 0);
        total++;
        if (got_src_q.size() != 32) begin bad++; $display("FAIL len_count: got %0d expected 32", got_src_q.size()); end
        for (int i = 0; i < 32; i++) begin
            word_t g = (i < got_src_q.size()) ? got_src_q[i] : 'x;
            total++;
            if (g !== sent_beats[i][DW-1:0]) begin
                bad++; $display("FAIL len_data[%0d]: got %h expected %h", i, g, sent_beats[i][DW-1:0]);
            end
        end
        total++;
        if (err_rise_at != 31) begin bad++; $display("FAIL len_err_rise: got %0d expected 31", err_rise_at); end
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL len_err_sticky: got %b expected 1", err_len); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL len_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_src_backpressure();
        for (int mode = 1; mode <= 2; mode++) begin
            drive_in(32, 31, mode);
            total++;
            if (got_src_q.size() != 32 || in_timeout) begin
                bad++; $display("FAIL bp%0d_count: got %0d expected 32", mode, got_src_q.size());
            end
            for (int i = 0; i < 32; i++) begin
                word_t g = (i < got_src_q.size()) ? got_src_q[i] : 'x;
                total++;
                if (g !== sent_beats[i][DW-1:0]) begin
                    bad++; $display("FAIL bp%0d_data[%0d]: got %h expected %h", mode, i, g, sent_beats[i][DW-1:0]);
                end
            end
            total++;
            if (flow_bad != 0) begin bad++; $display("FAIL bp%0d_flow: got %0d expected 0", mode, flow_bad); end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_out_packet();
        int lasts = 0;
        drive_out(64, 1000, 0);
        total++;
        if (got_m_q.size() != 64 || out_timeout) begin
            bad++; $display("FAIL pkt_count: got %0d expected 64", got_m_q.size());
        end
        for (int i = 0; i < 64; i++) begin
            beat_t g = (i < got_m_q.size()) ? got_m_q[i] : 'x;
            if (g[DW] === 1'b1) lasts++;
            total++;
            if (g !== exp_m_q[i]) begin
                bad++; $display("FAIL pkt_word[%0d]: got %h expected %h", i, g, exp_m_q[i]);
            end
        end
        total++;
        if (lasts != 1) begin bad++; $display("FAIL pkt_tlast_count: got %0d expected 1", lasts); end
        if (got_m_q.size() == 64) begin
            total++;
            if (got_m_q[63][DW] !== 1'b1) begin bad++; $display("FAIL pkt_tlast_pos: got %b expected 1", got_m_q[63][DW]); end
        end
        total++;
        if (out_bad != 0) begin bad++; $display("FAIL pkt_flow: got %0d expected 0", out_bad); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL pkt_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_out_stall();
        drive_out(32, 5, 10);
        total++;
        if (got_m_q.size() != 32 || out_timeout) begin
            bad++; $display("FAIL stall_count: got %0d expected 32", got_m_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            beat_t g = (i < got_m_q.size()) ? got_m_q[i] : 'x;
            total++;
            if (g !== exp_m_q[i]) begin
                bad++; $display("FAIL stall_word[%0d]: got %h expected %h", i, g, exp_m_q[i]);
            end
        end
        total++;
        if (out_bad != 0) begin bad++; $display("FAIL stall_flow: got %0d expected 0", out_bad); end
        total++;
        if (stall_seen < 1) begin bad++; $display("FAIL stall_dst_ready_low: got %0d expected >=1", stall_seen); end
    endtask

    task automatic test_trunc();
        bit exp_trunc;
        int lasts = 0;
        apply_reset();
        run = 1'b1;
        @(posedge clk); #1;
        drive_out(20, 1000, 0);
        total++;
        if (err_trunc !== 1'b0) begin bad++; $display("FAIL trunc_before: got %b expected 0", err_trunc); end
        exp_trunc = (ocount != 0);
        ocount = 0;
        run = 1'b0;
        @(posedge clk); #1;
        total++;
        if (err_trunc !== exp_trunc) begin bad++; $display("FAIL trunc_flag: got %b expected %b", err_trunc, exp_trunc); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL trunc_busy_idle: got %b expected 0", busy); end
        run = 1'b1;
        @(posedge clk); #1;
        drive_out(64, 1000, 0);
        for (int i = 0; i < 64; i++) begin
            beat_t g = (i < got_m_q.size()) ? got_m_q[i] : 'x;
            if (g[DW] === 1'b1) lasts++;
            total++;
            if (g !== exp_m_q[i]) begin
                bad++; $display("FAIL trunc_word[%0d]: got %h expected %h", i, g, exp_m_q[i]);
            end
        end
        total++;
        if (lasts != 1) begin bad++; $display("FAIL trunc_tlast_count: got %0d expected 1", lasts); end
        if (got_m_q.size() == 64) begin
            total++;
            if (got_m_q[63][DW] !== 1'b1) begin bad++; $display("FAIL trunc_tlast_pos: got %b expected 1", got_m_q[63][DW]); end
        end
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] obs;
        matw = 1'b1; run = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = $urandom; s_axis_tlast = 1'b0;
        src_ready = 1'b0;
        dst_valid = 1'b1; dst_data = $urandom; m_axis_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        obs = {s_axis_tready, src_valid, m_axis_tvalid, m_axis_tlast,
               dst_ready, err_len, err_trunc, busy};
        total++;
        if (obs !== 8'b0000_1000) begin
            bad++;
            $display("FAIL mid_reset_state: got %b expected %b", obs, 8'b0000_1000);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_param_load();
        test_len_error();
        test_src_backpressure();
        test_out_packet();
        test_out_stall();
        test_trunc();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
